// File: rtl/ast_pkg.sv
// Shared definitions for the AST pulse generator: state encoding,
// command bit positions and status byte layout.
package ast_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;
  localparam int CMD_CLEAR = 2;

  localparam int STU_BUSY    = 0;
  localparam int STU_SENS    = 1;
  localparam int STU_ACK     = 2;
  localparam int STU_TIMEOUT = 3;
  localparam int STU_OVERRUN = 4;
  localparam int STU_CNT_LSB = 5;
  localparam int STU_CNT_MSB = 7;

  // A programmed width of zero still produces a one-tick pulse.
  function automatic logic [7:0] eff_width(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

endpackage

// File: rtl/ast_pulse_if.sv
// Register-block / sensor side signals of the AST pulse generator.
interface ast_pulse_if;
  logic [7:0] cmd_ast;
  logic [7:0] cfg_pol;
  logic [7:0] cfg_width;
  logic       sensor_in;
  logic       ast_out;
  logic [7:0] stu_sensor;

  modport master (
    output cmd_ast, cfg_pol, cfg_width, sensor_in,
    input  ast_out, stu_sensor
  );

  modport slave (
    input  cmd_ast, cfg_pol, cfg_width, sensor_in,
    output ast_out, stu_sensor
  );
endinterface

// File: rtl/ast_sync.sv
// Multi-flop synchroniser for the asynchronous sensor feedback.
module ast_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // shift the raw input through the synchroniser chain
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ast_pulse.sv
// AST pulse generator: timed assert pulse toward the sensor followed by a
// bounded response window, with a sticky status byte for readback.
//
//   state    | meaning
//   IDLE     | ast_out follows live cfg_pol[0]; waiting for START
//   PULSE    | ast_out active for width*TICK_DIV cycles
//   WAIT_ACK | waiting for sens_act or ACK_WIN ticks to elapse
module ast_pulse
  import ast_pkg::*;
#(
  parameter int TICK_DIV    = 100,
  parameter int ACK_WIN     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  ast_pulse_if.slave   bus
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    ACK_LAST  = 8'(ACK_WIN - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    width_q, width_d;
  logic          pol_q, pol_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          to_q, to_d;
  logic          ovr_q, ovr_d;
  logic          ast_out_q, ast_out_d;
  logic [7:0]    stu_q, stu_d;

  logic start, abort, clear;
  logic sens_sync, sens_act;
  logic tick, pulse_done, win_done, launch;
  logic ack_evt, to_evt, cnt_evt, ovr_evt;
  logic unused_cfg;

  assign start = bus.cmd_ast[CMD_START];
  assign abort = bus.cmd_ast[CMD_ABORT];
  assign clear = bus.cmd_ast[CMD_CLEAR];
  assign unused_cfg = ^{bus.cmd_ast[7:3], bus.cfg_pol[7:2]};

  ast_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .d_i     (bus.sensor_in),
    .q_o     (sens_sync)
  );

  // sensor polarity follows the live config
  assign sens_act = sens_sync ^ bus.cfg_pol[1];

  assign tick       = (state_q != IDLE) && (presc_q == TICK_LAST);
  assign pulse_done = (state_q == PULSE) && tick && (tcnt_q == width_q - 8'd1);
  assign win_done   = (state_q == WAIT_ACK) && tick && (tcnt_q == ACK_LAST);
  assign launch     = (state_q == IDLE) && start && !abort;

  // ack wins over a coinciding window expiry; abort suppresses all events
  assign ack_evt = (state_q == WAIT_ACK) && sens_act && !abort;
  assign to_evt  = win_done && !sens_act && !abort;
  assign cnt_evt = pulse_done && !abort;
  assign ovr_evt = start && !abort && (state_q != IDLE);

  // state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start) state_d = PULSE;
        PULSE:    if (pulse_done) state_d = WAIT_ACK;
        WAIT_ACK: if (sens_act || win_done) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // next value of the pulse output
  always_comb begin
    ast_out_d = bus.cfg_pol[0];
    case (state_q)
      IDLE:     ast_out_d = launch ? ~bus.cfg_pol[0] : bus.cfg_pol[0];
      PULSE:    ast_out_d = (abort || pulse_done) ? pol_q : ~pol_q;
      WAIT_ACK: ast_out_d = pol_q;
      default:  ast_out_d = bus.cfg_pol[0];
    endcase
  end

  // timers, latched config and sticky status next values
  always_comb begin
    width_d = launch ? eff_width(bus.cfg_width) : width_q;
    pol_d   = launch ? bus.cfg_pol[0] : pol_q;

    if ((state_q == IDLE) || (state_d == IDLE)) begin
      presc_d = '0;
      tcnt_d  = 8'd0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (!tick)           tcnt_d = tcnt_q;
      else if (pulse_done) tcnt_d = 8'd0;
      else                 tcnt_d = tcnt_q + 8'd1;
    end

    if (cnt_evt)    cnt_d = clear ? 3'd1 : cnt_q + 3'd1;
    else if (clear) cnt_d = 3'd0;
    else            cnt_d = cnt_q;

    ack_d = ack_evt | (ack_q & ~clear);
    to_d  = to_evt  | (to_q  & ~clear);
    ovr_d = ovr_evt | (ovr_q & ~clear);

    stu_d = 8'h00;
    stu_d[STU_BUSY]                = (state_d != IDLE);
    stu_d[STU_SENS]                = sens_act;
    stu_d[STU_ACK]                 = ack_d;
    stu_d[STU_TIMEOUT]             = to_d;
    stu_d[STU_OVERRUN]             = ovr_d;
    stu_d[STU_CNT_MSB:STU_CNT_LSB] = cnt_d;
  end

  // datapath and output registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      tcnt_q    <= 8'd0;
      width_q   <= 8'd1;
      pol_q     <= 1'b0;
      cnt_q     <= 3'd0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
      ovr_q     <= 1'b0;
      ast_out_q <= 1'b0;
      stu_q     <= 8'h00;
    end else begin
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      width_q   <= width_d;
      pol_q     <= pol_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      to_q      <= to_d;
      ovr_q     <= ovr_d;
      ast_out_q <= ast_out_d;
      stu_q     <= stu_d;
    end
  end

  assign bus.ast_out    = ast_out_q;
  assign bus.stu_sensor = stu_q;

endmodule

// File: doc/ast_pulse.md
Name: ast_pulse

Overview:
- Consumes the command and config bytes produced by the AST register block (cmd_ast, cfg_pol, cfg_width).
- Generates a timed assert pulse on ast_out toward the sensor, then waits in a bounded window for the sensor's response.
- Returns a status byte (stu_sensor) that the register block exposes for readback.

Parameters:
- TICK_DIV, 100: clk_sys cycles per width tick (1 us at 100 MHz). Must be ≥ 2.
- ACK_WIN, 255: length of the response window after the pulse, in ticks. Range 1..255.
- SYNC_STAGES, 2: synchroniser depth for sensor_in. Must be ≥ 2.

Ports:
- clk_sys, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- cmd_ast, in, 8: command strobe. Nonzero for exactly one cycle per bus write; 0 otherwise.
- cfg_pol, in, 8: [0] ast_out active level (0 = active-high); [1] sensor_in active level (0 = active-high); [7:2] ignored.
- cfg_width, in, 8: pulse width in ticks. 0 is treated as 1.
- sensor_in, in, 1: asynchronous sensor feedback.
- ast_out, out, 1: registered pulse output to the sensor.
- stu_sensor, out, 8: registered status byte.

Behaviour:
- Reset is asynchronous, active-low, on clk_sys. Values on reset:
  - state = IDLE
  - ast_out = 0
  - stu_sensor = 8'h00
  - prescaler, tick counter, pulse count and synchronisers = 0
- Command decode (bits of cmd_ast; several bits may be set in the same cycle):
  - bit0 START
  - bit1 ABORT
  - bit2 CLEAR
  - bits[7:3] ignored
  - Priority: ABORT beats START. CLEAR applies in parallel with either.
- States: IDLE, PULSE, WAIT_ACK.
- IDLE:
  - ast_out = cfg_pol[0], so the inactive level follows the live config and is registered with 1 cycle delay.
  - On START in cycle N:
    - latch width W = max(cfg_width, 1) and polarity P = cfg_pol[0]
    - clear the prescaler and tick counter
    - go to PULSE
    - ast_out = ~P from cycle N+1
- PULSE:
  - ast_out is held active for exactly W*TICK_DIV cycles.
  - cfg changes during the pulse have no effect.
  - At the end of the final tick: ast_out returns to P, pulse count increments (3 bits, 7 wraps to 0), tick counter clears, go to WAIT_ACK.
- WAIT_ACK:
  - Sensor is sampled through SYNC_STAGES flops, then XORed with cfg_pol[1] (live) to give sens_act.
  - If sens_act = 1: set ack (sticky), go to IDLE.
  - Else, after ACK_WIN ticks: set timeout (sticky), go to IDLE.
  - If the ack arrives in the same cycle as window expiry, ack wins and timeout is not set.
- ABORT, in any state:
  - next cycle: ast_out = inactive level, state = IDLE
  - count, ack and timeout are unchanged
  - in IDLE, ABORT is a no-op
- START while in PULSE or WAIT_ACK (without ABORT): ignored, sets overrun (sticky).
- CLEAR: clears ack, timeout, overrun and the pulse count on the next cycle. Current state and ast_out are unaffected.
  - If CLEAR arrives together with an event that sets one of those bits, the set wins.
  - This includes count increment: on collision the count becomes 1.
- stu_sensor bits, updated every cycle (registered):
  - [0] busy (state ≠ IDLE)
  - [1] sens_act
  - [2] ack
  - [3] timeout
  - [4] overrun
  - [7:5] pulse count
- Prescaler: counts 0..TICK_DIV-1 while in PULSE or WAIT_ACK; held at 0 in IDLE. A tick is the cycle in which the prescaler equals TICK_DIV-1.
- Reset mid-pulse: ast_out drops to 0 asynchronously; all state is lost.

Decomposition:
- Shared package ast_pkg holds:
  - state encoding (IDLE = 2'd0, PULSE = 2'd1, WAIT_ACK = 2'd2)
  - command bit indices (CMD_START = 0, CMD_ABORT = 1, CMD_CLEAR = 2)
  - stu_sensor bit indices
- One sub-module, ast_sync: a SYNC_STAGES-deep synchroniser for sensor_in, with async reset to 0.
- The FSM, prescaler, counters and status register stay in ast_pulse.

Test Plan:
- Bench parameters: TICK_DIV = 4, ACK_WIN = 8.
- Scenario 1: cfg_pol = 0, cfg_width = 3, cmd_ast = 01 at cycle N, sensor_in = 1 at cycle N+20 → ast_out high during cycles N+1..N+12 (12 cycles); stu_sensor[0] = 1 during the operation; ack seen about 3 cycles after N+20; stu_sensor = 8'h26 (count 1, ack, sens_act), busy = 0.
- Scenario 2: cfg_width = 0, START, no sensor response → pulse lasts 4 cycles; timeout asserted 32 cycles after pulse end; stu_sensor[3] = 1, [7:5] = 1.
- Scenario 3: cfg_pol = 01, START, then cmd_ast = 02 two cycles into the pulse → ast_out goes 1 → 0 → 1, restoring the idle level 1 on the next cycle; count remains 0; busy = 0.
- Scenario 4: START, then START again during PULSE → stu_sensor[4] = 1 and the pulse width is unchanged. Then cmd_ast = 04 → bits [4:2] and [7:5] read 0.
- Scenario 5: 9 completed pulses (each ack'd) → count reads 1 (wrap); CLEAR issued in the same cycle as the 10th pulse end → count reads 1.
- Scenario 6: rst_n asserted mid-PULSE → ast_out = 0 and stu_sensor = 00 immediately. After release, a START behaves exactly as in scenario 1.
